// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the alu_pipe block: opcodes, shifter states, CLA group size.
package alu_pipe_pkg;

  localparam int GRP = 4;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    SH_IDLE  = 2'd0,
    SH_SHIFT = 2'd1,
    SH_DONE  = 2'd2
  } sh_state_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_pipe_cla.sv
// Combinational two-level carry-lookahead adder built from 4-bit groups.
module alu_pipe_cla
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             cout
);

  localparam int NG = WIDTH / GRP;

  if (WIDTH < GRP || (WIDTH % GRP) != 0) begin : g_bad_width
    $error("alu_pipe_cla: WIDTH must be a non-zero multiple of 4");
  end

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;
  logic [NG:0]      grp_c;

  assign g = a & b;
  assign p = a ^ b;

  // carry[i] is the carry into bit i; group carries are resolved before the bits.
  always_comb begin
    grp_g = '0;
    grp_p = '0;
    grp_c = '0;
    carry = '0;
    for (int k = 0; k < NG; k++) begin
      grp_p[k] = &p[k*GRP +: GRP];
      grp_g[k] = g[k*GRP+3]
               | (p[k*GRP+3] & g[k*GRP+2])
               | (p[k*GRP+3] & p[k*GRP+2] & g[k*GRP+1])
               | (p[k*GRP+3] & p[k*GRP+2] & p[k*GRP+1] & g[k*GRP]);
    end
    grp_c[0] = cin;
    for (int k = 0; k < NG; k++) begin
      grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
    end
    for (int k = 0; k < NG; k++) begin
      carry[k*GRP] = grp_c[k];
      for (int j = 1; j < GRP; j++) begin
        carry[k*GRP+j] = g[k*GRP+j-1] | (p[k*GRP+j-1] & carry[k*GRP+j-1]);
      end
    end
  end

  assign sum  = p ^ carry;
  assign cout = grp_c[NG];

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready integer ALU with registered result and flags.
// Define ALU_PIPE_SHIFT_EN to build the iterative 1-bit-per-cycle shifter for SLL/SRL.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int MSB = WIDTH - 1;
  localparam int SW  = clog2(WIDTH);

  logic             s1_valid_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic             s2_valid_q;
  logic [WIDTH-1:0] res_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  logic             accept;
  logic             s1_adv;
  logic             sh_ready;
  logic [WIDTH-1:0] shift_res;
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] carry;
  logic             cla_cout;
  logic             ovf_raw;
  logic             unused_carry_lo;
  logic [WIDTH-1:0] res_d;
  logic             cout_d;
  logic             ovf_d;

  assign accept   = in_valid && in_ready;
  assign s1_adv   = s1_valid_q && sh_ready && (!s2_valid_q || out_ready);
  assign in_ready = !rst && (!s1_valid_q || s1_adv);

  assign is_sub = (op_q == OP_SUB) || (op_q == OP_SLT);
  assign b_eff  = is_sub ? ~b_q : b_q;

  alu_pipe_cla #(.WIDTH(WIDTH)) u_cla (
    .a     (a_q),
    .b     (b_eff),
    .cin   (is_sub),
    .sum   (sum),
    .carry (carry),
    .cout  (cla_cout)
  );

  // Carry into the MSB differing from carry out is the same test as the sign-compare form.
  assign ovf_raw         = carry[MSB] ^ cla_cout;
  assign unused_carry_lo = ^carry[MSB-1:0];

`ifdef ALU_PIPE_SHIFT_EN
  sh_state_e        sh_state_q;
  logic [WIDTH-1:0] sh_q;
  logic [SW-1:0]    cnt_q;
  logic             is_shift_in;
  logic [SW-1:0]    shamt_in;

  assign is_shift_in = (op == OP_SLL) || (op == OP_SRL);
  assign shamt_in    = b[SW-1:0];
  assign sh_ready    = (sh_state_q != SH_SHIFT);
  assign shift_res   = sh_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_state_q <= SH_IDLE;
      sh_q       <= '0;
      cnt_q      <= '0;
    end else if (accept) begin
      sh_q       <= a;
      cnt_q      <= shamt_in;
      sh_state_q <= (is_shift_in && shamt_in != '0) ? SH_SHIFT : SH_IDLE;
    end else begin
      case (sh_state_q)
        SH_SHIFT: begin
          sh_q  <= (op_q == OP_SRL) ? (sh_q >> 1) : (sh_q << 1);
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == SW'(1)) sh_state_q <= SH_DONE;
        end
        SH_DONE: if (s1_adv) sh_state_q <= SH_IDLE;
        default: ;
      endcase
    end
  end
`else
  assign sh_ready  = 1'b1;
  assign shift_res = '0;
`endif

  always_comb begin
    res_d  = '0;
    cout_d = 1'b0;
    ovf_d  = 1'b0;
    case (op_q)
      OP_AND: res_d = a_q & b_q;
      OP_OR:  res_d = a_q | b_q;
      OP_NOR: res_d = ~(a_q | b_q);
      OP_ADD, OP_SUB: begin
        res_d  = sum;
        cout_d = cla_cout;
        ovf_d  = ovf_raw;
      end
      OP_SLT: begin
        res_d  = {{(WIDTH-1){1'b0}}, sum[MSB] ^ ovf_raw};
        cout_d = cla_cout;
      end
      default: res_d = shift_res;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_AND;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      a_q        <= a;
      b_q        <= b;
      op_q       <= op;
    end else if (s1_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else if (s1_adv) begin
      s2_valid_q <= 1'b1;
      res_q      <= res_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
      zero_q     <= (res_d == '0);
    end else if (out_ready) begin
      s2_valid_q <= 1'b0;
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = res_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=8 with hand-computed expectations.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   op = OP_AND;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  logic         zero;

  int vectors = 0;
  int miscompares = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op into an idle pipe and wait (bounded) for its result.
  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] er, input logic ec, input logic ev,
                        input logic ez, input int elat, input int elow);
    int n;
    int low;
    op = o;
    a = av;
    b = bv;
    in_valid = 1'b1;
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    n = 1;
    low = 0;
    while (!out_valid && n < 40) begin
      if (!in_ready) low++;
      tick();
      n++;
    end
    chk({tag, ".latency"}, 32'(n), 32'(elat));
    chk({tag, ".ready_low"}, 32'(low), 32'(elow));
    chk({tag, ".result"}, 32'(result), 32'(er));
    chk({tag, ".cout"}, 32'(cout), 32'(ec));
    chk({tag, ".overflow"}, 32'(overflow), 32'(ev));
    chk({tag, ".zero"}, 32'(zero), 32'(ez));
    tick();
    chk({tag, ".drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int  sent;
    int  recv;
    int  stray;
    logic acc;
    logic emit;

    rst = 1'b1;
    tick();
    tick();
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.result", 32'(result), 32'd0);
    chk("reset.cout", 32'(cout), 32'd0);
    chk("reset.overflow", 32'(overflow), 32'd0);
    chk("reset.zero", 32'(zero), 32'd0);
    chk("reset.in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;

    //           tag        op      a      b      result c     v     z     lat low
    run_op("add_ovf",  OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 2, 0);
    run_op("sub_eq",   OP_SUB, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1, 2, 0);
    run_op("nor",      OP_NOR, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b1, 2, 0);
    run_op("and",      OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 2, 0);
    run_op("or",       OP_OR,  8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0, 1'b0, 2, 0);
    run_op("add_wrap", OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 2, 0);
    run_op("sub_neg",  OP_SUB, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0, 2, 0);
    run_op("slt_lt",   OP_SLT, 8'h80, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0, 2, 0);
    run_op("slt_ge",   OP_SLT, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 2, 0);
    run_op("slt_ovf",  OP_SLT, 8'h7F, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 2, 0);
`ifdef ALU_PIPE_SHIFT_EN
    run_op("sll3",     OP_SLL, 8'h03, 8'h03, 8'h18, 1'b0, 1'b0, 1'b0, 5, 3);
    run_op("srl0",     OP_SRL, 8'h80, 8'h00, 8'h80, 1'b0, 1'b0, 1'b0, 2, 0);
    run_op("srl4",     OP_SRL, 8'hF0, 8'h04, 8'h0F, 1'b0, 1'b0, 1'b0, 6, 4);
    run_op("sll1",     OP_SLL, 8'h81, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 3, 1);
`else
    run_op("sll_off",  OP_SLL, 8'h03, 8'h03, 8'h00, 1'b0, 1'b0, 1'b1, 2, 0);
    run_op("srl_off",  OP_SRL, 8'h80, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 2, 0);
`endif

    // Four back-to-back ADDs with the consumer stalled for the first three cycles.
    sent = 0;
    recv = 0;
    for (int c = 0; c < 14; c++) begin
      out_ready = (c >= 3);
      in_valid = (sent < 4);
      op = OP_ADD;
      a = W'(sent + 1);
      b = W'(sent + 1);
      #1;
      if (c == 2) begin
        chk("bp.in_ready_stalled", 32'(in_ready), 32'd0);
        chk("bp.accepts_before_stall", 32'(sent), 32'd2);
      end
      acc = in_valid && in_ready;
      emit = out_valid && out_ready;
      if (emit) begin
        chk($sformatf("bp.result%0d", recv), 32'(result), 32'(2 * (recv + 1)));
        recv++;
      end
      if (acc) sent++;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp.sent", 32'(sent), 32'd4);
    chk("bp.received", 32'(recv), 32'd4);
    chk("bp.idle", 32'(out_valid), 32'd0);

    // Reset while an operation is in flight; nothing may emerge for it.
`ifdef ALU_PIPE_SHIFT_EN
    op = OP_SLL;
    a = 8'h01;
    b = 8'h07;
    in_valid = 1'b1;
    #1;
    tick();
    in_valid = 1'b0;
    tick();
`else
    op = OP_ADD;
    a = 8'h11;
    b = 8'h22;
    in_valid = 1'b1;
    #1;
    tick();
    in_valid = 1'b0;
`endif
    rst = 1'b1;
    tick();
    chk("rst_mid.out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid.result", 32'(result), 32'd0);
    chk("rst_mid.flags", 32'({cout, overflow, zero}), 32'd0);
    rst = 1'b0;
    stray = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) stray++;
      tick();
    end
    chk("rst_mid.no_stray_beat", 32'(stray), 32'd0);
    run_op("add_after_rst", OP_ADD, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0, 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined successor to the 4-bit ALU slice: a WIDTH-bit integer ALU built from 4-bit carry-lookahead groups, with valid/ready handshakes on input and output and registered result and flags. It sits between operand fetch and writeback and absorbs backpressure without losing or reordering operations. An optional iterative shifter adds multi-cycle shift operations.

## Interface
- WIDTH, 32: operand/result width; a multiple of 4, at least 4.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; the low log2(WIDTH) bits are the shift amount for shifts.
- op  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 NOR, 011 SLL, 101 SRL.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer takes the beat.
- result  out  WIDTH  registered result.
- cout  out  1  carry out of the MSB (ADD/SUB/SLT); 0 for all other ops.
- overflow  out  1  signed overflow (ADD/SUB only); 0 otherwise.
- zero  out  1  result equals 0, for every op.

## Operation
- Two register stages:
  - S1 holds a, b, op and s1_valid.
  - S2 holds result, cout, overflow, zero and s2_valid (out_valid = s2_valid).
- Accept: a beat transfers when in_valid && in_ready.
- in_ready = !rst && (!s1_valid || s1_adv).
- s1_adv = s1_valid && shifter idle-or-done && (!s2_valid || out_ready).
- Output: a beat leaves when out_valid && out_ready.
- Simultaneous accept and output in the same cycle is legal, giving full throughput (1 op/cycle) for non-shift ops.
- Arithmetic:
  - SUB and SLT compute a + ~b + 1; ADD computes a + b.
  - Carries come from a two-level CLA over 4-bit groups: per-group G/P, then group carries.
  - overflow = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]), where b' is the inverted b for SUB.
- SLT: result = {0…, sum[MSB] ^ ovf_sub}; cout holds the subtract carry; overflow is reported as 0.
- Logic ops (AND/OR/NOR): cout = 0, overflow = 0.
- Shift ops without the macro: result 0 and flags 0 (zero = 1), single pass.
- Data in S2 holds stable while out_valid && !out_ready.

## Timing
- Reset: s1_valid = 0, s2_valid = 0, shifter IDLE; result, cout, overflow and zero registers all read 0; in_ready = 0 during the reset cycle.
- Reset mid-operation discards all in-flight beats, including a partial shift; no result is produced for them.
- Latency, non-shift ops: out_valid rises 2 cycles after the accept edge when S2 is free.
- Latency, shifts (macro on): 2 + shamt cycles. shamt = 0 gives 2 cycles.
- in_ready stays low while a shift iterates in S1.
- Backpressure: with out_ready low, at most 2 beats are held (S1 and S2); in_ready drops on the third beat.

## Configuration
- ALU_PIPE_SHIFT_EN defined:
  - Adds shifter FSM IDLE → SHIFT → DONE → IDLE.
  - An SLL/SRL entering S1 with shamt ≠ 0 moves IDLE → SHIFT; the working register shifts 1 bit per cycle (logical, zero fill) and a down-counter counts shamt.
  - Counter reaching 0 → DONE; DONE advances to S2 under s1_adv, then → IDLE.
  - shamt = 0 skips SHIFT.
  - Shift flags: cout = 0, overflow = 0, zero per result.
- ALU_PIPE_SHIFT_EN undefined: no FSM or counter is built; shift opcodes behave as stated in Operation.

## Structure
- Package alu_pipe_pkg holds:
  - the op encoding constants (OP_AND … OP_SRL);
  - the shifter state typedef;
  - the group size constant GRP = 4;
  - a function clog2 used for the shamt width.
- One sub-module, alu_pipe_cla (parameter WIDTH): takes a, b', cin and produces the sum, per-bit carries and carry out. It is purely combinational and instantiated once between S1 and S2.
- A WIDTH that is not a multiple of 4 is an elaboration error.

## Test plan
- WIDTH=8, ADD a=0x7F b=0x01 → result 0x80, overflow 1, cout 0, zero 0; out_valid 2 cycles after accept.
- SUB a=0x05 b=0x05 → result 0x00, zero 1, cout 1, overflow 0. NOR a=0xF0 b=0x0F → result 0x00, zero 1, cout 0.
- SLT a=0x80 b=0x01 → result 0x01; SLT a=0x01 b=0x80 → result 0x00; SLT a=0x7F b=0x80 (overflowing subtract) → result 0x00, overflow reported 0.
- Backpressure: stream 4 ADDs back-to-back with out_ready low for 3 cycles → in_ready low after 2 accepts; all 4 results emerge in order with none lost or duplicated.
- Macro on: SLL a=0x03 b=3 → result 0x18, out_valid 5 cycles after accept, in_ready low during iteration. SRL a=0x80 b=0 → result 0x80 with latency 2.
- Macro on: assert rst during the second SHIFT cycle of SLL a=0x01 b=7 → next cycle out_valid 0 and outputs 0; the following ADD completes normally with latency 2.
